// File: rtl/timer_pkg.sv
// Shared definitions for the microwave countdown timer: FSM encodings, BCD digit limits
// and the default done-beep length.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } timer_state_e;

    localparam logic [3:0] MAX_ONES = 4'd9;
    localparam logic [3:0] MAX_TENS = 4'd5;
    localparam logic [3:0] MAX_MINS = 4'd9;

    localparam int BEEP_CYCLES_DEF = 300;

endpackage

// File: rtl/timer_countdown_if.sv
// Keypad/control inputs and display/status outputs of the countdown timer.
// The master side is the panel driving keys; the slave side is the timer itself.
interface timer_countdown_if;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       startn;
    logic       stopn;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       zero;
    logic       running;
    logic       done_beep;

    modport master (
        output D, loadn, pgt_1Hz, startn, stopn,
        input  sec_ones, sec_tens, mins, zero, running, done_beep
    );

    modport slave (
        input  D, loadn, pgt_1Hz, startn, stopn,
        output sec_ones, sec_tens, mins, zero, running, done_beep
    );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with saturating load and a borrow request for the
// next-higher digit when it wraps from 0 to MAXVAL.
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter logic [3:0] MAXVAL = MAX_ONES
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       clr,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       borrow
);

    logic [3:0] q_r;

    // Digit register: clear beats load beats decrement.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            q_r <= 4'd0;
        end else if (clr) begin
            q_r <= 4'd0;
        end else if (load) begin
            q_r <= (d > MAXVAL) ? MAXVAL : d;
        end else if (dec) begin
            q_r <= (q_r == 4'd0) ? MAXVAL : (q_r - 4'd1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q      = q_r;
    assign borrow = dec && (q_r == 4'd0);

endmodule

// File: rtl/timer_countdown.sv
// MM:SS microwave countdown timer with keypad digit entry and run/pause/done control.
// Optional feature macro: TIMER_DONE_BEEP_EN (timed done-beep; otherwise DONE lasts one clk).
module timer_countdown
    import timer_pkg::*;
#(
    parameter int BEEP_CYCLES = BEEP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             clearn,
    timer_countdown_if.slave tif
);

    timer_state_e state_r;
    timer_state_e state_next_s;

    logic       loadn_prev_r;
    logic       pgt_prev_r;
    logic       stopn_prev_r;
    logic       load_edge_s;
    logic       tick_s;
    logic       stop_fall_s;

    logic [3:0] ones_s;
    logic [3:0] tens_s;
    logic [3:0] mins_s;
    logic       ones_borrow_s;
    logic       tens_borrow_s;
    logic       unused_mins_borrow_s;

    logic       zero_s;
    logic       one_left_s;
    logic       key_load_s;
    logic       dec_s;
    logic       clr_s;
    logic       beep_end_s;

    // Previous-cycle copies of the key, 1 Hz and stop inputs for edge detection.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            loadn_prev_r <= 1'b0;
            pgt_prev_r   <= 1'b0;
            stopn_prev_r <= 1'b0;
        end else begin
            loadn_prev_r <= tif.loadn;
            pgt_prev_r   <= tif.pgt_1Hz;
            stopn_prev_r <= tif.stopn;
        end
    end

    assign load_edge_s = !tif.loadn && loadn_prev_r;
    assign tick_s      = tif.pgt_1Hz && !pgt_prev_r;
    assign stop_fall_s = !tif.stopn && stopn_prev_r;

    assign zero_s     = (mins_s == 4'd0) && (tens_s == 4'd0) && (ones_s == 4'd0);
    assign one_left_s = (mins_s == 4'd0) && (tens_s == 4'd0) && (ones_s == 4'd1);

`ifdef TIMER_DONE_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

    logic [BEEP_W-1:0] beep_cnt_r;
    logic              done_beep_r;

    assign beep_end_s = (beep_cnt_r == BEEP_W'(BEEP_CYCLES - 1));

    // Beep length counter and registered beeper drive, active for the whole DONE stay.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            beep_cnt_r  <= '0;
            done_beep_r <= 1'b0;
        end else begin
            if (state_r == ST_DONE) begin
                beep_cnt_r <= beep_cnt_r + BEEP_W'(1);
            end else begin
                beep_cnt_r <= '0;
            end
            done_beep_r <= (state_next_s == ST_DONE);
        end
    end

    assign tif.done_beep = done_beep_r;
`else
    localparam int unused_beep_cycles = BEEP_CYCLES;

    assign beep_end_s    = 1'b1;
    assign tif.done_beep = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_r <= ST_ENTRY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a held stopn always overrides startn.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ENTRY: begin
                if (tif.stopn && !tif.startn && !zero_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_ENTRY;
                end
            end
            ST_RUN: begin
                if (!tif.stopn) begin
                    state_next_s = ST_PAUSE;
                end else if (tick_s && one_left_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop_fall_s) begin
                    state_next_s = ST_ENTRY;
                end else if (tif.stopn && !tif.startn && !zero_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (stop_fall_s || beep_end_s) begin
                    state_next_s = ST_ENTRY;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_ENTRY;
        endcase
    end

    // Keys only land while the state holds, so any transition takes precedence.
    assign key_load_s = ((state_r == ST_ENTRY) || (state_r == ST_PAUSE))
                        && (state_next_s == state_r)
                        && load_edge_s
                        && (tif.D <= MAX_ONES);
    assign dec_s      = (state_r == ST_RUN) && tif.stopn && tick_s && !zero_s;
    assign clr_s      = (state_r == ST_PAUSE) && stop_fall_s;

    bcd_digit_down #(.MAXVAL(MAX_ONES)) u_ones (
        .clk    (clk),
        .clearn (clearn),
        .clr    (clr_s),
        .load   (key_load_s),
        .dec    (dec_s),
        .d      (tif.D),
        .q      (ones_s),
        .borrow (ones_borrow_s)
    );

    bcd_digit_down #(.MAXVAL(MAX_TENS)) u_tens (
        .clk    (clk),
        .clearn (clearn),
        .clr    (clr_s),
        .load   (key_load_s),
        .dec    (ones_borrow_s),
        .d      (ones_s),
        .q      (tens_s),
        .borrow (tens_borrow_s)
    );

    bcd_digit_down #(.MAXVAL(MAX_MINS)) u_mins (
        .clk    (clk),
        .clearn (clearn),
        .clr    (clr_s),
        .load   (key_load_s),
        .dec    (tens_borrow_s),
        .d      (tens_s),
        .q      (mins_s),
        .borrow (unused_mins_borrow_s)
    );

    assign tif.sec_ones = ones_s;
    assign tif.sec_tens = tens_s;
    assign tif.mins     = mins_s;
    assign tif.zero     = zero_s;
    assign tif.running  = (state_r == ST_RUN);

endmodule
